// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared ALU datapath.
// Accepts an op per grant, executes it in one cycle and returns a tagged result with N/Z/V/C flags.
module alu_share_arbiter #(
    parameter int unsigned size = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [2:0]      req0_op,
    input  logic [size-1:0] req0_a,
    input  logic [size-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [2:0]      req1_op,
    input  logic [size-1:0] req1_a,
    input  logic [size-1:0] req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [size-1:0] rsp_out,
    output logic [3:0]      rsp_flags_n_z_v_c,
    output logic [3:0]      status_flags_n_z_v_c,
    output logic            busy
);
    localparam int unsigned W = size;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_PASA = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;
    logic           ptr;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           id_q;

    logic           grant;
    logic           accept;
    logic           is_sub;
    logic           is_arith;
    logic [W-1:0]   b_eff;
    logic [W:0]     sum;
    logic [W-1:0]   alu_out;
    logic [3:0]     alu_flags;

    // Lone requester wins outright; a tie goes to the priority pointer.
    assign grant      = (req0_valid && req1_valid) ? ptr : req1_valid;
    assign req0_ready = (state == IDLE) && !rst && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && !rst && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    // Shared datapath working from the captured operands.
    always_comb begin
        is_sub   = (op_q == OP_SUB);
        is_arith = (op_q == OP_ADD) || is_sub;
        b_eff    = is_sub ? ~b_q : b_q;
        sum      = {1'b0, a_q} + {1'b0, b_eff} + (W+1)'(is_sub);
        alu_out  = '0;
        case (op_q)
            OP_AND:         alu_out = a_q & b_q;
            OP_OR:          alu_out = a_q | b_q;
            OP_XOR:         alu_out = a_q ^ b_q;
            OP_ADD, OP_SUB: alu_out = sum[W-1:0];
            OP_NOT:         alu_out = ~a_q;
            OP_PASA:        alu_out = a_q;
            default:        alu_out = b_q;
        endcase
        alu_flags = {alu_out[W-1],
                     ~|alu_out,
                     is_arith && (a_q[W-1] == b_eff[W-1]) && (sum[W-1] != a_q[W-1]),
                     is_arith && sum[W]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            ptr                  <= 1'b0;
            op_q                 <= '0;
            a_q                  <= '0;
            b_q                  <= '0;
            id_q                 <= 1'b0;
            rsp_valid            <= 1'b0;
            rsp_id               <= 1'b0;
            rsp_out              <= '0;
            rsp_flags_n_z_v_c    <= '0;
            status_flags_n_z_v_c <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= grant ? req1_op : req0_op;
                        a_q   <= grant ? req1_a  : req0_a;
                        b_q   <= grant ? req1_b  : req0_b;
                        id_q  <= grant;
                        ptr   <= ~grant;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_out              <= alu_out;
                    rsp_flags_n_z_v_c    <= alu_flags;
                    rsp_id               <= id_q;
                    status_flags_n_z_v_c <= alu_flags;
                    rsp_valid            <= 1'b1;
                    state                <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester front end for a shared N-bit ALU. It accepts an operation (opcode, in_a, in_b) from either of two requesters over valid/ready handshakes and arbitrates round-robin between them. It executes the operation on one internal ALU datapath with the team's N/Z/V/C flag semantics and returns the tagged result over a valid/ready response channel. It sits between the instruction sequencer and the ALU, so one datapath serves both the main pipeline and the address/loop unit.

## Interface
- size, 4, datapath width in bits (≥2)
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid
- req0_op  input  3  requester 0 opcode
- req0_a, req0_b  input  size  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that issued the result (0/1)
- rsp_out  output  size  result
- rsp_flags_n_z_v_c  output  4  flags of the result, bit3 N, bit2 Z, bit1 V, bit0 C
- status_flags_n_z_v_c  output  4  flags of the last completed operation; held until the next one completes
- busy  output  1  high whenever state ≠ IDLE

## Operation
- Opcodes:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 ADD (a+b)
  - 100 SUB (a−b computed as a+~b+1)
  - 101 NOT a
  - 110 PASS a
  - 111 PASS b
- Flags:
  - N = out[size-1]; Z = ~|out.
  - ADD/SUB: C = carry-out of the size-bit sum (for SUB, C=1 means no borrow); V = signed overflow (operand sign bits equal, result sign differs, after b inversion for SUB).
  - All other ops: V=0, C=0.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: pick a grant. If only one req valid, grant it. If both valid, grant the requester named by the priority pointer. Assert that requester's ready combinationally; the other ready stays 0. On the handshake, capture op/a/b/id into registers, set the pointer to the non-granted requester, and go to EXEC. If neither is valid, stay in IDLE.
  - EXEC: compute from the captured registers. Load rsp_out, rsp_flags_n_z_v_c, rsp_id and status_flags_n_z_v_c; set rsp_valid=1; go to RESP.
  - RESP: hold all rsp_* stable while rsp_ready=0. When rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
- req*_ready is 0 in EXEC and RESP, and 0 in any cycle where rst=1.
- Priority pointer changes only on a grant. A single-valid grant also updates it, so the other requester gets priority next.
- ADD/SUB arithmetic is size+1 bits internally; rsp_out is truncated to size bits.

## Timing
- Reset (registered on the clk edge with rst=1): state IDLE, rsp_valid 0, rsp_id 0, rsp_out 0, rsp_flags 0, status_flags 0, priority pointer 0, busy 0.
- Reset mid-operation aborts the in-flight op with no response. A pending rsp is dropped.
- Latency: an op accepted in cycle T has rsp_valid high from cycle T+2.
- If rsp_ready=1 at T+2, the next accept is possible in T+3. Peak throughput is one op per 3 cycles.
- Back-pressure: rsp_ready low holds RESP for any number of cycles. Requests are not accepted meanwhile.
- Requesters must hold valid/op/a/b stable until ready. The block samples them only in the handshake cycle.
- Simultaneous valid on both requesters with the pointer at 1: requester 1 is granted and the pointer becomes 0.

## Test plan
- After reset, size=4, req0 XOR a=0xA b=0x5 -> req0_ready=1 in T; rsp_valid at T+2 with rsp_out=0xF, flags=1000, rsp_id=0.
- req1 SUB a=0x3 b=0x3 -> rsp_out=0x0, flags=0101 (Z=1, C=1 no borrow); ADD a=0x7 b=0x1 -> rsp_out=0x8, flags=1010 (N, V); ADD 0xF+0x1 -> 0x0, flags=0101.
- Both requesters valid continuously for 4 ops -> grants alternate 0,1,0,1 (pointer starts 0); each rsp_id matches the requester; one accept per 3 cycles.
- Hold rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, both req*_ready=0, busy=1; release -> handshake, IDLE next cycle.
- Assert rst in EXEC, and separately in RESP -> next cycle all outputs are at reset values; no response is emitted; the next request is served normally with the pointer at 0.
- Single requester 1 valid with the pointer at 0 -> granted immediately; the pointer becomes 0; a following simultaneous request grants requester 0.
